// File: rtl/regfile.sv
// 32x32 register file, r0 reads zero; one synchronous write port, two combinational read ports.
// Writes become visible one edge later and reads take zero cycles; there is no backpressure, so every cycle can write.
module regfile (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  input  logic [31:0] data_writeReg,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB
);

  logic [31:0] decoded;
  logic [31:0] load_en;
  logic [31:0] regs [1:31];
  logic [31:0] rd_view [32];

  always_comb begin
    decoded = 32'd1 << ctrl_writeReg;
    load_en = decoded & {32{ctrl_writeEnable}};
  end

  // An X write enable evaluates false in the if, so the registers hold their values.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int k = 1; k < 32; k++) regs[k] <= 32'h0;
    end else begin
      for (int k = 1; k < 32; k++) begin
        if (load_en[k]) regs[k] <= data_writeReg;
      end
    end
  end

  // Entry 0 is a constant, so index 0 needs no special case in the read muxes.
  always_comb begin
    rd_view[0] = 32'h0;
    for (int k = 1; k < 32; k++) rd_view[k] = regs[k];
  end

  always_comb begin
    data_readRegA = rd_view[ctrl_readRegA];
    data_readRegB = rd_view[ctrl_readRegB];
  end

endmodule
